waveform_buffer_sender: RTL and testbench



---
 rtl/waveform_buffer_sender_if.sv | 27 ++
 rtl/waveform_buffer_sender.sv | 137 +++++++++++++
 tb/tb_waveform_buffer_sender.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_buffer_sender_if.sv
`default_nettype none
// ==========================================================================
// waveform_buffer_sender_if - capture-block handshake plus UART TX FIFO byte port
// Rev 1.0
// ==========================================================================
interface waveform_buffer_sender_if #(
  parameter int TX_WAVEFORM_BUFFER_WIDTH = 1024
);
  logic [1:TX_WAVEFORM_BUFFER_WIDTH] TX_BUFFER;
  logic                              TX_waveform_buffer_ready;
  logic                              TX_FIFO_ready;
  logic                              tx_fifo_full;
  logic [7:0]                        tx_data;
  logic                              tx_wr_en;
  logic                              busy;

  modport master (
    output TX_BUFFER, TX_waveform_buffer_ready, tx_fifo_full,
    input  TX_FIFO_ready, tx_data, tx_wr_en, busy
  );

  modport slave (
    input  TX_BUFFER, TX_waveform_buffer_ready, tx_fifo_full,
    output TX_FIFO_ready, tx_data, tx_wr_en, busy
  );
endinterface
`default_nettype wire

// File: rtl/waveform_buffer_sender.sv
`default_nettype none
// ==========================================================================
// waveform_buffer_sender - frames capture blocks as ESC 'W' <ESC-stuffed payload>
// for the UART TX FIFO. Define WAVEFORM_SENDER_CHECKSUM_EN to append an XOR checksum.
// Rev 1.0
// ==========================================================================
module waveform_buffer_sender #(
  parameter int         TX_WAVEFORM_BUFFER_BYTES = 8'h80,
  parameter int         TX_WAVEFORM_BUFFER_WIDTH = 8 * TX_WAVEFORM_BUFFER_BYTES,
  parameter int         BYTE_COUNTER_WIDTH       = 8,
  parameter logic [7:0] ESC_CHAR                 = 8'h10,
  parameter logic [7:0] HEADER_CHAR              = "W"
) (
  input  wire                      CLK100MHZ,
  input  wire                      reset,
  waveform_buffer_sender_if.slave  bus
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_HDR_ESC = 3'd1;
  localparam logic [2:0] c_ST_HDR_CMD = 3'd2;
  localparam logic [2:0] c_ST_PAYLOAD = 3'd3;
  localparam logic [2:0] c_ST_STUFF   = 3'd4;
`ifdef WAVEFORM_SENDER_CHECKSUM_EN
  localparam logic [2:0] c_ST_CKSUM       = 3'd5;
  localparam logic [2:0] c_ST_CKSUM_STUFF = 3'd6;
  localparam logic [2:0] c_ST_AFTER_DATA  = c_ST_CKSUM;
`else
  localparam logic [2:0] c_ST_AFTER_DATA  = c_ST_IDLE;
`endif

  localparam logic [BYTE_COUNTER_WIDTH-1:0] c_LAST_IDX  = BYTE_COUNTER_WIDTH'(TX_WAVEFORM_BUFFER_BYTES - 1);
  localparam logic [BYTE_COUNTER_WIDTH-1:0] c_COUNT_END = BYTE_COUNTER_WIDTH'(TX_WAVEFORM_BUFFER_BYTES);

  logic [2:0]                        r_state;
  logic [2:0]                        w_state_next;
  logic [1:TX_WAVEFORM_BUFFER_WIDTH] r_shift;
  logic [BYTE_COUNTER_WIDTH-1:0]     r_count;
  logic [7:0]                        r_tx_data;
  logic                              r_tx_wr_en;
  logic                              r_ready;
  logic                              r_busy;
  logic                              w_emit;
  logic                              w_load;
  logic [7:0]                        w_byte;
  logic [7:0]                        w_head;
`ifdef WAVEFORM_SENDER_CHECKSUM_EN
  logic [7:0]                        r_cksum;
`endif

  assign w_head = r_shift[1:8];

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE:    if (bus.TX_waveform_buffer_ready) w_state_next = c_ST_HDR_ESC;
      c_ST_HDR_ESC: if (!bus.tx_fifo_full) w_state_next = c_ST_HDR_CMD;
      c_ST_HDR_CMD: if (!bus.tx_fifo_full) w_state_next = c_ST_PAYLOAD;
      c_ST_PAYLOAD: begin
        if (!bus.tx_fifo_full) begin
          if (w_head == ESC_CHAR)        w_state_next = c_ST_STUFF;
          else if (r_count == c_LAST_IDX) w_state_next = c_ST_AFTER_DATA;
        end
      end
      // The counter was already bumped when the stuffed byte itself went out
      c_ST_STUFF: if (!bus.tx_fifo_full)
        w_state_next = (r_count == c_COUNT_END) ? c_ST_AFTER_DATA : c_ST_PAYLOAD;
`ifdef WAVEFORM_SENDER_CHECKSUM_EN
      c_ST_CKSUM: if (!bus.tx_fifo_full)
        w_state_next = (r_cksum == ESC_CHAR) ? c_ST_CKSUM_STUFF : c_ST_IDLE;
      c_ST_CKSUM_STUFF: if (!bus.tx_fifo_full) w_state_next = c_ST_IDLE;
`endif
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_load = (r_state == c_ST_IDLE) && bus.TX_waveform_buffer_ready;
    w_emit = (r_state != c_ST_IDLE) && !bus.tx_fifo_full;
    w_byte = 8'h00;
    case (r_state)
      c_ST_HDR_ESC:     w_byte = ESC_CHAR;
      c_ST_HDR_CMD:     w_byte = HEADER_CHAR;
      c_ST_PAYLOAD:     w_byte = w_head;
      c_ST_STUFF:       w_byte = ESC_CHAR;
`ifdef WAVEFORM_SENDER_CHECKSUM_EN
      c_ST_CKSUM:       w_byte = r_cksum;
      c_ST_CKSUM_STUFF: w_byte = ESC_CHAR;
`endif
      default:          w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_count    <= '0;
      r_tx_data  <= 8'h00;
      r_tx_wr_en <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
`ifdef WAVEFORM_SENDER_CHECKSUM_EN
      r_cksum    <= 8'h00;
`endif
    end else begin
      r_tx_wr_en <= w_emit;
      if (w_emit) r_tx_data <= w_byte;
      r_ready    <= (w_state_next == c_ST_IDLE);
      r_busy     <= (w_state_next != c_ST_IDLE);
      if (w_load) begin
        r_shift <= bus.TX_BUFFER;
        r_count <= '0;
`ifdef WAVEFORM_SENDER_CHECKSUM_EN
        r_cksum <= 8'h00;
`endif
      end else if (w_emit && (r_state == c_ST_PAYLOAD)) begin
        r_shift <= {r_shift[9:TX_WAVEFORM_BUFFER_WIDTH], 8'h00};
        r_count <= r_count + BYTE_COUNTER_WIDTH'(1);
`ifdef WAVEFORM_SENDER_CHECKSUM_EN
        r_cksum <= r_cksum ^ w_head;
`endif
      end
    end
  end

  assign bus.tx_data       = r_tx_data;
  assign bus.tx_wr_en      = r_tx_wr_en;
  assign bus.TX_FIFO_ready = r_ready;
  assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_waveform_buffer_sender.sv
`default_nettype none
// ==========================================================================
// tb_waveform_buffer_sender - drives capture blocks and FIFO back-pressure, compares
// the written byte stream against a frame model built from the framing rules. Rev 1.0
// ==========================================================================
module tb_waveform_buffer_sender;
  localparam int         N   = 128;
  localparam int         W   = 8 * N;
  localparam logic [7:0] ESC = 8'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  waveform_buffer_sender_if #(.TX_WAVEFORM_BUFFER_WIDTH(W)) bus ();
  waveform_buffer_sender dut (.CLK100MHZ(clk), .reset(rst), .bus(bus));

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         full_mode = 0;
  int         full_viol = 0;
  logic       full_s = 1'b0;
  logic [15:0] lfsr = 16'hACE1;
  logic [7:0] pay [N];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int         got_cyc [$];
  logic       got_rdy [$];
  logic       rdy_log [int];

  always @(posedge clk) begin
    cyc++;
    full_s = bus.tx_fifo_full;
  end

  // Byte collector and back-pressure generator
  always @(negedge clk) begin
    rdy_log[cyc] = bus.TX_FIFO_ready;
    if (bus.tx_wr_en === 1'b1) begin
      got_q.push_back(bus.tx_data);
      got_cyc.push_back(cyc);
      got_rdy.push_back(bus.TX_FIFO_ready);
      if (full_s === 1'b1) full_viol++;
    end
    case (full_mode)
      0: bus.tx_fifo_full = 1'b0;
      1: begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        bus.tx_fifo_full = lfsr[0];
      end
      default: bus.tx_fifo_full = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    got_rdy.delete();
  endtask

  // Reference frame: ESC, 'W', payload with every ESC doubled, optional stuffed XOR.
  function automatic void build_expected();
    exp_q.delete();
    exp_q.push_back(ESC);
    exp_q.push_back(8'h57);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(pay[i]);
      if (pay[i] == ESC) exp_q.push_back(ESC);
    end
`ifdef WAVEFORM_SENDER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < N; i++) x = x ^ pay[i];
      exp_q.push_back(x);
      if (x == ESC) exp_q.push_back(ESC);
    end
`endif
  endfunction

  function automatic logic [1:W] pack_payload();
    logic [1:W] b;
    for (int i = 0; i < N; i++) b[8*i+1 +: 8] = pay[i];
    return b;
  endfunction

  task automatic pulse_block();
    bus.TX_BUFFER = pack_payload();
    bus.TX_waveform_buffer_ready = 1'b1;
    tick();
    bus.TX_waveform_buffer_ready = 1'b0;
  endtask

  task automatic check_frame(input string name, input int budget);
    int k;
    int first_bad;
    k = 0;
    first_bad = -1;
    while (got_q.size() < exp_q.size() && k < budget) begin
      tick();
      k++;
    end
    repeat (4) tick();
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s length: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
    end
    total++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        first_bad = i;
        break;
      end
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s byte %0d: got %02h, expected %02h", name, first_bad,
               got_q[first_bad], exp_q[first_bad]);
    end
  endtask

  task automatic wait_count(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (got_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d bytes, expected at least %0d", name, got_q.size(), n);
    end
  endtask

  task automatic fill_incrementing();
    for (int i = 0; i < N; i++) pay[i] = 8'(i + 8'h20);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total += 4;
    if (bus.TX_FIFO_ready !== 1'b1) begin bad++; $display("FAIL reset TX_FIFO_ready: got %b, expected 1", bus.TX_FIFO_ready); end
    if (bus.tx_wr_en !== 1'b0)      begin bad++; $display("FAIL reset tx_wr_en: got %b, expected 0", bus.tx_wr_en); end
    if (bus.tx_data !== 8'h00)      begin bad++; $display("FAIL reset tx_data: got %02h, expected 00", bus.tx_data); end
    if (bus.busy !== 1'b0)          begin bad++; $display("FAIL reset busy: got %b, expected 0", bus.busy); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_incrementing();
    full_mode = 0;
    fill_incrementing();
    build_expected();
    clear_log();
    pulse_block();
    total += 2;
    if (bus.TX_FIFO_ready !== 1'b0) begin bad++; $display("FAIL incr ready after pulse: got %b, expected 0", bus.TX_FIFO_ready); end
    if (bus.busy !== 1'b1)          begin bad++; $display("FAIL incr busy after pulse: got %b, expected 1", bus.busy); end
    check_frame("incr", 400);
    if (got_q.size() == exp_q.size() && got_q.size() > 1) begin
      int rdy_hi;
      rdy_hi = 0;
      for (int i = 0; i < got_rdy.size() - 1; i++) if (got_rdy[i] !== 1'b0) rdy_hi++;
      total += 3;
      if (got_cyc[got_cyc.size()-1] - got_cyc[0] != got_q.size() - 1) begin
        bad++;
        $display("FAIL incr consecutive: span %0d cycles, expected %0d", got_cyc[got_cyc.size()-1] - got_cyc[0], got_q.size() - 1);
      end
      if (rdy_hi != 0) begin bad++; $display("FAIL incr ready during frame: high in %0d writes, expected 0", rdy_hi); end
      if (rdy_log[got_cyc[got_cyc.size()-1] + 1] !== 1'b1) begin
        bad++;
        $display("FAIL incr ready after last write: got %b, expected 1", rdy_log[got_cyc[got_cyc.size()-1] + 1]);
      end
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL incr busy after frame: got %b, expected 0", bus.busy); end
  endtask

  task automatic test_single_esc();
    full_mode = 0;
    for (int i = 0; i < N; i++) pay[i] = 8'h00;
    pay[5] = ESC;
    build_expected();
    clear_log();
    pulse_block();
    check_frame("single_esc", 400);
  endtask

  task automatic test_all_esc();
    full_mode = 0;
    for (int i = 0; i < N; i++) pay[i] = ESC;
    build_expected();
    clear_log();
    pulse_block();
    check_frame("all_esc", 600);
  endtask

  task automatic test_cksum_payload();
    full_mode = 0;
    for (int i = 0; i < N; i++) pay[i] = 8'h00;
    pay[0] = 8'h01;
    pay[1] = 8'h11;
    build_expected();
    clear_log();
    pulse_block();
    check_frame("cksum_payload", 400);
  endtask

  task automatic test_lfsr_full();
    full_mode = 1;
    fill_incrementing();
    build_expected();
    clear_log();
    full_viol = 0;
    pulse_block();
    check_frame("lfsr_full", 2000);
    total++;
    if (full_viol != 0) begin bad++; $display("FAIL lfsr_full write while full: got %0d, expected 0", full_viol); end
    full_mode = 0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      full_mode = 2;
      for (int i = 0; i < N; i++)
        pay[i] = ($urandom_range(0, 3) == 0) ? ESC : 8'($urandom_range(0, 255));
      build_expected();
      clear_log();
      full_viol = 0;
      pulse_block();
      check_frame("random", 3000);
      total++;
      if (full_viol != 0) begin bad++; $display("FAIL random write while full: got %0d, expected 0", full_viol); end
    end
    full_mode = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    full_mode = 0;
    fill_incrementing();
    build_expected();
    clear_log();
    pulse_block();
    wait_count(42, 200, "reset_mid");
    rst = 1'b1;
    #1;
    n = got_q.size();
    total++;
    if (bus.tx_wr_en !== 1'b0) begin bad++; $display("FAIL reset_mid wr_en in reset: got %b, expected 0", bus.tx_wr_en); end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total += 2;
    if (bus.TX_FIFO_ready !== 1'b1) begin bad++; $display("FAIL reset_mid ready after release: got %b, expected 1", bus.TX_FIFO_ready); end
    if (bus.busy !== 1'b0)          begin bad++; $display("FAIL reset_mid busy after release: got %b, expected 0", bus.busy); end
    repeat (6) tick();
    total++;
    if (got_q.size() != n) begin bad++; $display("FAIL reset_mid stray writes: got %0d bytes, expected %0d", got_q.size(), n); end
    for (int i = 0; i < N; i++) pay[i] = 8'($urandom_range(0, 255));
    build_expected();
    clear_log();
    pulse_block();
    check_frame("reset_mid_fresh", 400);
  endtask

  task automatic test_second_pulse();
    full_mode = 0;
    fill_incrementing();
    build_expected();
    clear_log();
    pulse_block();
    wait_count(20, 200, "second_pulse");
    for (int i = 0; i < N; i++) pay[i] = 8'($urandom_range(0, 255));
    pulse_block();
    check_frame("second_pulse", 400);
    repeat (30) tick();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL second_pulse extra frame: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_pulse_at_end();
    full_mode = 0;
    fill_incrementing();
    build_expected();
    clear_log();
    pulse_block();
    wait_count(exp_q.size() - 1, 400, "pulse_at_end");
    total++;
    if (bus.TX_FIFO_ready !== 1'b0) begin bad++; $display("FAIL pulse_at_end ready at last emit: got %b, expected 0", bus.TX_FIFO_ready); end
    for (int i = 0; i < N; i++) pay[i] = 8'($urandom_range(0, 255));
    pulse_block();
    check_frame("pulse_at_end", 400);
    repeat (30) tick();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL pulse_at_end extra frame: got %0d bytes, expected %0d", got_q.size(), exp_q.size()); end
  endtask

  initial begin
    bus.TX_BUFFER = '0;
    bus.TX_waveform_buffer_ready = 1'b0;
    test_reset();
    test_incrementing();
    test_single_esc();
    test_all_esc();
    test_cksum_payload();
    test_lfsr_full();
    test_random();
    test_reset_mid();
    test_second_pulse();
    test_pulse_at_end();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
